// File: rtl/prog_mem_arbiter_if.sv
// Read-request port between one requester (fetch or load unit) and the
// program memory arbiter.
interface prog_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 4
) ();
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/prog_mem_arbiter.sv
// Round-robin arbiter sharing one synchronous program memory between a fetch
// port (a) and a data/table port (b); responses return in issue order.
module prog_mem_arbiter #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 4,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                sys_clk,
    input  logic                reset_n,
    prog_mem_arbiter_if.slave   a,
    prog_mem_arbiter_if.slave   b,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_en,
    input  logic [DATA_W-1:0]   mem_dout,
    output logic                busy
);
    typedef struct packed {
        logic v;
        logic b;
    } tag_t;

    tag_t [RD_LAT:0]   tag_q;
    logic              last_b_q;
    logic              a_rvalid_q;
    logic              b_rvalid_q;
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;

    logic sel_b_c;
    logic gnt_a_c;
    logic gnt_b_c;
    logic gnt_any_c;
    logic any_v_c;

    // Tie goes to the port not served last; no grant while reset is asserted.
    always_comb begin
        sel_b_c = b.req;
        if (a.req && b.req) begin
            sel_b_c = ~last_b_q;
        end
        gnt_a_c   = reset_n & a.req & ~sel_b_c;
        gnt_b_c   = reset_n & b.req & sel_b_c;
        gnt_any_c = gnt_a_c | gnt_b_c;
    end

    always_comb begin
        any_v_c = 1'b0;
        for (int i = 0; i <= int'(RD_LAT); i++) begin
            any_v_c = any_v_c | tag_q[i].v;
        end
    end

    // Tag pipe stage 0 lines up with mem_en; the tail lines up with mem_dout.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            last_b_q   <= 1'b1;
            mem_addr   <= '0;
            mem_en     <= 1'b0;
            tag_q      <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            busy       <= 1'b0;
        end else begin
            if (gnt_any_c) begin
                last_b_q <= gnt_b_c;
                mem_addr <= gnt_b_c ? b.addr : a.addr;
            end
            mem_en     <= gnt_any_c;
            tag_q      <= {tag_q[RD_LAT-1:0], tag_t'{v: gnt_any_c, b: gnt_b_c}};
            a_rvalid_q <= tag_q[RD_LAT].v & ~tag_q[RD_LAT].b;
            b_rvalid_q <= tag_q[RD_LAT].v & tag_q[RD_LAT].b;
            if (tag_q[RD_LAT].v && !tag_q[RD_LAT].b) begin
                a_rdata_q <= mem_dout;
            end
            if (tag_q[RD_LAT].v && tag_q[RD_LAT].b) begin
                b_rdata_q <= mem_dout;
            end
            // Tail tag becomes rvalid next cycle, so busy covers the rvalid cycle.
            busy <= gnt_any_c | any_v_c;
        end
    end

    assign a.gnt    = gnt_a_c;
    assign b.gnt    = gnt_b_c;
    assign a.rvalid = a_rvalid_q;
    assign b.rvalid = b_rvalid_q;
    assign a.rdata  = a_rdata_q;
    assign b.rdata  = b_rdata_q;
endmodule
